// File: rtl/product_bcd_formatter.sv
// product_bcd_formatter: converts a product word to sign + packed BCD using
// a one-bit-per-clock shift-add-3 (double-dabble) sequence.
`default_nettype none

module product_bcd_formatter #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5,
  parameter bit SIGNED = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [WIDTH-1:0]      in_data,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic                  sign,
  output logic [4*DIGITS-1:0]   bcd
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    CONVERT = 1'b1
  } state_t;

  state_t              state;
  logic [WIDTH-1:0]    mag;
  logic [4*DIGITS-1:0] work;
  logic [CW-1:0]       count;
  logic                neg;

  logic                in_neg;
  logic [4*DIGITS-1:0] corrected;
  logic [4*DIGITS-1:0] next_work;

  assign in_neg   = SIGNED && in_data[WIDTH-1];
  assign in_ready = (state == IDLE);

  // Add-3 correction happens before each shift, so the final value needs none.
  always_comb begin
    corrected = work;
    for (int d = 0; d < DIGITS; d++) begin
      if (work[4*d +: 4] >= 4'd5) begin
        corrected[4*d +: 4] = work[4*d +: 4] + 4'd3;
      end
    end
    next_work = {corrected[4*DIGITS-2:0], mag[WIDTH-1]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      mag       <= '0;
      work      <= '0;
      count     <= '0;
      neg       <= 1'b0;
      out_valid <= 1'b0;
      sign      <= 1'b0;
      bcd       <= '0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            mag   <= in_neg ? (~in_data) + WIDTH'(1) : in_data;
            neg   <= in_neg;
            work  <= '0;
            count <= '0;
            state <= CONVERT;
          end
        end
        CONVERT: begin
          work  <= next_work;
          mag   <= {mag[WIDTH-2:0], 1'b0};
          count <= count + CW'(1);
          if (count == CW'(WIDTH - 1)) begin
            bcd       <= next_work;
            sign      <= neg;
            out_valid <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
